// File: rtl/fpu_mul_cfg.sv
// Parametrised sequential IEEE-754 multiplier (half/single/double) with RISC-V rounding modes and exception flags.
// Optional build macro FPU_MUL_FTZ_EN: flush subnormal inputs and tiny results to signed zero.
module fpu_mul_cfg #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din1,
  input  logic [W-1:0] din2,
  input  logic [2:0]   rnd_mode,
  input  logic         dval,
  output logic [W-1:0] result,
  output logic [4:0]   flags,
  output logic         rdy,
  output logic         busy
);
  localparam int M    = MAN_W + 1;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [EW-1:0] EMIN  = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] EMAX  = EW'(BIAS);
  localparam logic signed [EW-1:0] E_ONE = EW'(1);
  localparam logic [W-2:0] INF  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-2:0] MAXF = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [3:0] {
    IDLE, UNPACK, SPECIAL, NORM_A, NORM_B, MULT, NORM_1, NORM_2, ROUND, PACK, OUT
  } state_e;
  typedef enum logic [2:0] {
    RM_RNE = 3'd0, RM_RTZ = 3'd1, RM_RDN = 3'd2, RM_RUP = 3'd3, RM_RMM = 3'd4
  } rm_e;

  state_e               state_q, state_d;
  rm_e                  rm_q, rm_d;
  logic [W-1:0]         a_q, a_d, b_q, b_d, pres_q, pres_d, res_q, res_d;
  logic [4:0]           pflg_q, pflg_d, flg_q, flg_d;
  logic                 sign_q, sign_d, stk_q, stk_d, tiny_q, tiny_d, inx_q, inx_d;
  logic                 rdy_q, rdy_d, busy_q, busy_d;
  logic signed [EW-1:0] ea_q, ea_d, eb_q, eb_d, ep_q, ep_d;
  logic [M-1:0]         ma_q, ma_d, mb_q, mb_d, man_q, man_d;
  logic [2*M-1:0]       prod_q, prod_d;

  logic [EXP_W-1:0] fea, feb;
  logic [MAN_W-1:0] fma, fmb;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic [M-1:0] mhi;
  logic [M:0]   rsum;
  logic g, r, s, lsb, inx, inc;

  assign fea = a_q[W-2 -: EXP_W];
  assign feb = b_q[W-2 -: EXP_W];
  assign fma = a_q[MAN_W-1:0];
  assign fmb = b_q[MAN_W-1:0];
  assign a_nan  = (&fea) & (|fma);
  assign b_nan  = (&feb) & (|fmb);
  assign a_snan = a_nan & ~fma[MAN_W-1];
  assign b_snan = b_nan & ~fmb[MAN_W-1];
  assign a_inf  = (&fea) & ~(|fma);
  assign b_inf  = (&feb) & ~(|fmb);
`ifdef FPU_MUL_FTZ_EN
  assign a_zero = ~(|fea);
  assign b_zero = ~(|feb);
`else
  assign a_zero = ~(|fea) & ~(|fma);
  assign b_zero = ~(|feb) & ~(|fmb);
`endif

  // Normalised product keeps its hidden bit at the MSB; the low half feeds guard/round/sticky.
  assign mhi  = prod_q[2*M-1 -: M];
  assign lsb  = prod_q[M];
  assign g    = prod_q[M-1];
  assign r    = prod_q[M-2];
  assign s    = (|prod_q[M-3:0]) | stk_q;
  assign inx  = g | r | s;
  assign rsum = {1'b0, mhi} + {{M{1'b0}}, inc};

  always_comb begin
    case (rm_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign_q & inx;
      RM_RUP:  inc = ~sign_q & inx;
      RM_RMM:  inc = g;
      default: inc = g & (r | s | lsb);
    endcase
  end

  always_comb begin
    state_d = state_q;  rm_d = rm_q;     a_d = a_q;       b_d = b_q;
    pres_d  = pres_q;   pflg_d = pflg_q; res_d = res_q;   flg_d = flg_q;
    sign_d  = sign_q;   stk_d = stk_q;   tiny_d = tiny_q; inx_d = inx_q;
    ea_d    = ea_q;     eb_d = eb_q;     ep_d = ep_q;
    ma_d    = ma_q;     mb_d = mb_q;     man_d = man_q;   prod_d = prod_q;
    rdy_d   = 1'b0;     busy_d = busy_q;
    case (state_q)
      IDLE: begin
        busy_d = dval;
        if (dval) begin
          a_d     = din1;
          b_d     = din2;
          rm_d    = (rnd_mode > 3'd4) ? RM_RNE : rm_e'(rnd_mode);
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        sign_d  = a_q[W-1] ^ b_q[W-1];
        ea_d    = (fea == '0) ? EMIN : $signed({2'b00, fea}) - EMAX;
        eb_d    = (feb == '0) ? EMIN : $signed({2'b00, feb}) - EMAX;
        ma_d    = {fea != '0, fma};
        mb_d    = {feb != '0, fmb};
        state_d = SPECIAL;
      end
      SPECIAL: begin
        state_d = OUT;
        if (a_nan | b_nan) begin
          pres_d = QNAN;
          pflg_d = {a_snan | b_snan, 4'b0000};
        end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
          pres_d = QNAN;
          pflg_d = 5'b10000;
        end else if (a_inf | b_inf) begin
          pres_d = {sign_d ^ sign_d ^ sign_q, INF};
          pflg_d = '0;
        end else if (a_zero | b_zero) begin
          pres_d = {sign_q, {(W-1){1'b0}}};
          pflg_d = '0;
        end else begin
          state_d = NORM_A;
        end
      end
      NORM_A: begin
        if (!ma_q[M-1]) begin
          ma_d = ma_q << 1;
          ea_d = ea_q - E_ONE;
        end else state_d = NORM_B;
      end
      NORM_B: begin
        if (!mb_q[M-1]) begin
          mb_d = mb_q << 1;
          eb_d = eb_q - E_ONE;
        end else state_d = MULT;
      end
      MULT: begin
        // Exponent is pre-biased by one so the product MSB carries the 2's place.
        prod_d  = {{M{1'b0}}, ma_q} * {{M{1'b0}}, mb_q};
        ep_d    = ea_q + eb_q + E_ONE;
        stk_d   = 1'b0;
        tiny_d  = 1'b0;
        state_d = NORM_1;
      end
      NORM_1: begin
        if (!prod_q[2*M-1]) begin
          prod_d = prod_q << 1;
          ep_d   = ep_q - E_ONE;
        end else state_d = NORM_2;
      end
      NORM_2: begin
`ifdef FPU_MUL_FTZ_EN
        tiny_d  = (ep_q < EMIN);
        state_d = ROUND;
`else
        if (ep_q < EMIN) begin
          prod_d = prod_q >> 1;
          stk_d  = stk_q | prod_q[0];
          ep_d   = ep_q + E_ONE;
          tiny_d = 1'b1;
        end else state_d = ROUND;
`endif
      end
      ROUND: begin
        man_d   = rsum[M] ? rsum[M:1] : rsum[M-1:0];
        ep_d    = rsum[M] ? ep_q + E_ONE : ep_q;
        inx_d   = inx;
        state_d = PACK;
      end
      PACK: begin
        state_d = OUT;
        if (ep_q > EMAX) begin
          pflg_d = 5'b00101;
          case (rm_q)
            RM_RTZ:  pres_d = {sign_q, MAXF};
            RM_RDN:  pres_d = sign_q ? {1'b1, INF} : {1'b0, MAXF};
            RM_RUP:  pres_d = sign_q ? {1'b1, MAXF} : {1'b0, INF};
            default: pres_d = {sign_q, INF};
          endcase
`ifdef FPU_MUL_FTZ_EN
        end else if (tiny_q) begin
          pres_d = {sign_q, {(W-1){1'b0}}};
          pflg_d = 5'b00011;
`endif
        end else begin
          pres_d = {sign_q,
                    man_q[M-1] ? (ep_q[EXP_W-1:0] + EMAX[EXP_W-1:0]) : {EXP_W{1'b0}},
                    man_q[M-2:0]};
          pflg_d = {3'b000, tiny_q & inx_q, inx_q};
        end
      end
      OUT: begin
        res_d   = pres_q;
        flg_d   = pflg_q;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;  rm_q <= RM_RNE;  a_q <= '0;     b_q <= '0;
      pres_q  <= '0;    pflg_q <= '0;    res_q <= '0;   flg_q <= '0;
      sign_q  <= 1'b0;  stk_q <= 1'b0;   tiny_q <= 1'b0; inx_q <= 1'b0;
      ea_q    <= '0;    eb_q <= '0;      ep_q <= '0;
      ma_q    <= '0;    mb_q <= '0;      man_q <= '0;   prod_q <= '0;
      rdy_q   <= 1'b0;  busy_q <= 1'b0;
    end else begin
      state_q <= state_d; rm_q <= rm_d;     a_q <= a_d;       b_q <= b_d;
      pres_q  <= pres_d;  pflg_q <= pflg_d; res_q <= res_d;   flg_q <= flg_d;
      sign_q  <= sign_d;  stk_q <= stk_d;   tiny_q <= tiny_d; inx_q <= inx_d;
      ea_q    <= ea_d;    eb_q <= eb_d;     ep_q <= ep_d;
      ma_q    <= ma_d;    mb_q <= mb_d;     man_q <= man_d;   prod_q <= prod_d;
      rdy_q   <= rdy_d;   busy_q <= busy_d;
    end
  end

  assign result = res_q;
  assign flags  = flg_q;
  assign rdy    = rdy_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_fpu_mul_cfg.sv
// Directed bench for fpu_mul_cfg: single-precision instance plus a half-precision instance.
module tb_fpu_mul_cfg;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din1, din2, result;
  logic [2:0]  rnd_mode;
  logic        dval, rdy, busy;
  logic [4:0]  flags;
  logic [15:0] h_din1, h_din2, h_result;
  logic [2:0]  h_rm;
  logic        h_dval, h_rdy, h_busy;
  logic [4:0]  h_flags;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fpu_mul_cfg u_dut (
    .clk(clk), .rst_n(rst_n), .din1(din1), .din2(din2), .rnd_mode(rnd_mode),
    .dval(dval), .result(result), .flags(flags), .rdy(rdy), .busy(busy)
  );

  fpu_mul_cfg #(.EXP_W(5), .MAN_W(10)) u_half (
    .clk(clk), .rst_n(rst_n), .din1(h_din1), .din2(h_din2), .rnd_mode(h_rm),
    .dval(h_dval), .result(h_result), .flags(h_flags), .rdy(h_rdy), .busy(h_busy)
  );

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                        output logic [31:0] r, output logic [4:0] f, output int lat, output bit bok);
    @(negedge clk);
    din1 = a; din2 = b; rnd_mode = rm; dval = 1'b1;
    @(posedge clk); #1;
    dval = 1'b0;
    lat = 0;
    bok = (busy === 1'b1);
    while (rdy !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (busy !== 1'b1) bok = 1'b0;
    end
    r = result; f = flags;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h exp 00000000", result); end
    n_vec++; if (flags !== 5'b0) begin n_err++; $display("FAIL reset_flags got %b exp 00000", flags); end
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy got %b exp 0", rdy); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] r; logic [4:0] f; int lat; bit bok;
    run_op(32'h40400000, 32'h40200000, 3'b000, r, f, lat, bok);
    n_vec++; if (r !== 32'h40F00000) begin n_err++; $display("FAIL basic_result got %h exp 40f00000", r); end
    n_vec++; if (f !== 5'b00000) begin n_err++; $display("FAIL basic_flags got %b exp 00000", f); end
    n_vec++; if (lat != 11) begin n_err++; $display("FAIL basic_latency got %0d exp 11", lat); end
    n_vec++; if (!bok) begin n_err++; $display("FAIL basic_busy got low exp high throughout"); end
    run_op(32'h3F800000, 32'h40000000, 3'b000, r, f, lat, bok);
    n_vec++; if (lat != 11) begin n_err++; $display("FAIL one_times_two_latency got %0d exp 11", lat); end
    run_op(32'h3FC00000, 32'h3FC00000, 3'b000, r, f, lat, bok);
    n_vec++; if (r !== 32'h40100000) begin n_err++; $display("FAIL sq_1p5_result got %h exp 40100000", r); end
    n_vec++; if (lat != 10) begin n_err++; $display("FAIL sq_1p5_latency got %0d exp 10", lat); end
  endtask

  task automatic test_special();
    logic [31:0] r; logic [4:0] f; int lat; bit bok;
    run_op(32'h7F800000, 32'h00000000, 3'b000, r, f, lat, bok);
    n_vec++; if (r !== 32'h7FC00000) begin n_err++; $display("FAIL inf_zero_result got %h exp 7fc00000", r); end
    n_vec++; if (f !== 5'b10000) begin n_err++; $display("FAIL inf_zero_flags got %b exp 10000", f); end
    n_vec++; if (lat != 3) begin n_err++; $display("FAIL inf_zero_latency got %0d exp 3", lat); end
    run_op(32'h7F800001, 32'h3F800000, 3'b000, r, f, lat, bok);
    n_vec++; if (r !== 32'h7FC00000) begin n_err++; $display("FAIL snan_result got %h exp 7fc00000", r); end
    n_vec++; if (f !== 5'b10000) begin n_err++; $display("FAIL snan_flags got %b exp 10000", f); end
    run_op(32'h7FC00000, 32'h3F800000, 3'b000, r, f, lat, bok);
    n_vec++; if (f !== 5'b00000) begin n_err++; $display("FAIL qnan_flags got %b exp 00000", f); end
    run_op(32'h7F800000, 32'hC0000000, 3'b000, r, f, lat, bok);
    n_vec++; if (r !== 32'hFF800000) begin n_err++; $display("FAIL inf_neg_result got %h exp ff800000", r); end
    run_op(32'h80000000, 32'h40000000, 3'b000, r, f, lat, bok);
    n_vec++; if (r !== 32'h80000000) begin n_err++; $display("FAIL negzero_result got %h exp 80000000", r); end
  endtask

  task automatic test_overflow();
    logic [31:0] r; logic [4:0] f; int lat; bit bok;
    run_op(32'h7F7FFFFF, 32'h40000000, 3'b000, r, f, lat, bok);
    n_vec++; if (r !== 32'h7F800000) begin n_err++; $display("FAIL ovf_rne_result got %h exp 7f800000", r); end
    n_vec++; if (f !== 5'b00101) begin n_err++; $display("FAIL ovf_rne_flags got %b exp 00101", f); end
    run_op(32'h7F7FFFFF, 32'h40000000, 3'b001, r, f, lat, bok);
    n_vec++; if (r !== 32'h7F7FFFFF) begin n_err++; $display("FAIL ovf_rtz_result got %h exp 7f7fffff", r); end
    n_vec++; if (f !== 5'b00101) begin n_err++; $display("FAIL ovf_rtz_flags got %b exp 00101", f); end
    run_op(32'hFF7FFFFF, 32'h40000000, 3'b010, r, f, lat, bok);
    n_vec++; if (r !== 32'hFF800000) begin n_err++; $display("FAIL ovf_rdn_result got %h exp ff800000", r); end
    run_op(32'h7F7FFFFF, 32'h40000000, 3'b010, r, f, lat, bok);
    n_vec++; if (r !== 32'h7F7FFFFF) begin n_err++; $display("FAIL ovf_rdn_pos_result got %h exp 7f7fffff", r); end
    run_op(32'hFF7FFFFF, 32'h40000000, 3'b011, r, f, lat, bok);
    n_vec++; if (r !== 32'hFF7FFFFF) begin n_err++; $display("FAIL ovf_rup_neg_result got %h exp ff7fffff", r); end
  endtask

  task automatic test_round();
    logic [31:0] r; logic [4:0] f; int lat; bit bok;
    run_op(32'h3F800001, 32'h3F800001, 3'b001, r, f, lat, bok);
    n_vec++; if (r !== 32'h3F800002) begin n_err++; $display("FAIL rnd_rtz_result got %h exp 3f800002", r); end
    n_vec++; if (f !== 5'b00001) begin n_err++; $display("FAIL rnd_rtz_flags got %b exp 00001", f); end
    run_op(32'h3F800001, 32'h3F800001, 3'b011, r, f, lat, bok);
    n_vec++; if (r !== 32'h3F800003) begin n_err++; $display("FAIL rnd_rup_result got %h exp 3f800003", r); end
    n_vec++; if (f !== 5'b00001) begin n_err++; $display("FAIL rnd_rup_flags got %b exp 00001", f); end
    run_op(32'h3F800001, 32'h3F800001, 3'b000, r, f, lat, bok);
    n_vec++; if (r !== 32'h3F800002) begin n_err++; $display("FAIL rnd_rne_result got %h exp 3f800002", r); end
    run_op(32'hBF800001, 32'h3F800001, 3'b010, r, f, lat, bok);
    n_vec++; if (r !== 32'hBF800003) begin n_err++; $display("FAIL rnd_rdn_neg_result got %h exp bf800003", r); end
  endtask

  task automatic test_underflow();
    logic [31:0] r; logic [4:0] f; int lat; bit bok;
    run_op(32'h00000001, 32'h3F000000, 3'b000, r, f, lat, bok);
    n_vec++; if (r !== 32'h00000000) begin n_err++; $display("FAIL unf_rne_result got %h exp 00000000", r); end
`ifdef FPU_MUL_FTZ_EN
    n_vec++; if (f !== 5'b00000) begin n_err++; $display("FAIL unf_rne_flags got %b exp 00000", f); end
    n_vec++; if (lat != 3) begin n_err++; $display("FAIL unf_latency got %0d exp 3", lat); end
`else
    n_vec++; if (f !== 5'b00011) begin n_err++; $display("FAIL unf_rne_flags got %b exp 00011", f); end
    n_vec++; if (lat != 58) begin n_err++; $display("FAIL unf_latency got %0d exp 58", lat); end
`endif
    run_op(32'h00000001, 32'h3F000000, 3'b011, r, f, lat, bok);
`ifdef FPU_MUL_FTZ_EN
    n_vec++; if (r !== 32'h00000000) begin n_err++; $display("FAIL unf_rup_result got %h exp 00000000", r); end
    n_vec++; if (f !== 5'b00000) begin n_err++; $display("FAIL unf_rup_flags got %b exp 00000", f); end
`else
    n_vec++; if (r !== 32'h00000001) begin n_err++; $display("FAIL unf_rup_result got %h exp 00000001", r); end
    n_vec++; if (f !== 5'b00011) begin n_err++; $display("FAIL unf_rup_flags got %b exp 00011", f); end
`endif
  endtask

  task automatic test_back_to_back();
    int rdy_cnt = 0; int idle_cnt = 0; int first_rdy = -1; int second_rdy = -1; int bad_res = 0; int w = 0;
    @(negedge clk);
    din1 = 32'h40400000; din2 = 32'h40200000; rnd_mode = 3'b000; dval = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1) idle_cnt++;
      if (rdy === 1'b1) begin
        rdy_cnt++;
        if (first_rdy < 0) first_rdy = k; else second_rdy = k;
        if (result !== 32'h40F00000) bad_res++;
      end
    end
    dval = 1'b0;
    n_vec++; if (rdy_cnt != 2) begin n_err++; $display("FAIL b2b_rdy_count got %0d exp 2", rdy_cnt); end
    n_vec++; if (first_rdy != 11) begin n_err++; $display("FAIL b2b_first_rdy got %0d exp 11", first_rdy); end
    n_vec++; if (second_rdy != 23) begin n_err++; $display("FAIL b2b_second_rdy got %0d exp 23", second_rdy); end
    n_vec++; if (idle_cnt != 0) begin n_err++; $display("FAIL b2b_busy_gap got %0d exp 0", idle_cnt); end
    n_vec++; if (bad_res != 0) begin n_err++; $display("FAIL b2b_result bad count %0d exp 0", bad_res); end
    while (busy === 1'b1 && w < 40) begin @(posedge clk); #1; w++; end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_drain busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    int rdy_cnt = 0; int busy_cnt = 0;
    @(negedge clk);
    din1 = 32'h40400000; din2 = 32'h40200000; rnd_mode = 3'b000; dval = 1'b1;
    @(posedge clk); #1 dval = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL rstmid_rdy got %b exp 0", rdy); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL rstmid_result got %h exp 00000000", result); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (rdy === 1'b1) rdy_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
    n_vec++; if (rdy_cnt != 0) begin n_err++; $display("FAIL rstmid_no_rdy got %0d pulses exp 0", rdy_cnt); end
    n_vec++; if (busy_cnt != 0) begin n_err++; $display("FAIL rstmid_no_busy got %0d cycles exp 0", busy_cnt); end
  endtask

  task automatic test_half();
    int lat = 0;
    @(negedge clk);
    h_din1 = 16'h3C00; h_din2 = 16'hC000; h_rm = 3'b000; h_dval = 1'b1;
    @(posedge clk); #1 h_dval = 1'b0;
    while (h_rdy !== 1'b1 && lat < 400) begin @(posedge clk); #1; lat++; end
    n_vec++; if (h_result !== 16'hC000) begin n_err++; $display("FAIL half_result got %h exp c000", h_result); end
    n_vec++; if (h_flags !== 5'b00000) begin n_err++; $display("FAIL half_flags got %b exp 00000", h_flags); end
    n_vec++; if (lat != 11) begin n_err++; $display("FAIL half_latency got %0d exp 11", lat); end
  endtask

  initial begin
    rst_n = 1'b0; dval = 1'b0; din1 = '0; din2 = '0; rnd_mode = '0;
    h_dval = 1'b0; h_din1 = '0; h_din2 = '0; h_rm = '0;
    test_reset();
    test_basic();
    test_special();
    test_overflow();
    test_round();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    test_half();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before bench completed");
    $fatal(1, "watchdog");
  end
endmodule
